mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, directly downstream of EX.
- Consumes the EX/MEM register outputs and drives a ready/valid data-memory bus.
- Handles byte-lane steering and load extension, and owns the MEM/WB pipeline register.
- Raises stall_o while a memory access is outstanding; the hazard unit uses it to freeze upstream stages.

Parameters:
- BUBBLE_INST, 32'h0000_0013, instruction value loaded into inst_wb_o on bubble/flush (ADDI x0,x0,0).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- alu_mem_i  in  32  ALU result / effective address
- rs2_mem_i  in  32  store data (already forwarded)
- pc4_mem_i  in  32  PC+4
- MemRW_mem_i  in  1  1 = store
- WBSel_mem_i  in  2  writeback select
- RegWEn_mem_i  in  1  register write enable
- rsW_mem_i  in  5  destination register
- inst_mem_i  in  32  instruction
- enable_i  in  1  MEM/WB register update enable
- reset_i  in  1  synchronous flush of MEM/WB, qualified by enable_i
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  write strobe
- dmem_addr_o  out  32  word-aligned address ({alu[31:2],2'b00})
- dmem_wdata_o  out  32  lane-steered store data
- dmem_be_o  out  4  byte enables
- dmem_rdata_i  in  32  read data, valid when dmem_ready_i=1
- dmem_ready_i  in  1  access completes this cycle
- stall_o  out  1  access outstanding
- misalign_o  out  1  current MEM instruction is a misaligned access
- alu_wb_o, ld_wb_o, pc4_wb_o, inst_wb_o  out  32 each  MEM/WB register outputs
- WBSel_wb_o  out  2; RegWEn_wb_o  out  1; rsW_wb_o  out  5

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is asynchronous and active-low.
- On reset:
  - FSM goes to IDLE.
  - All MEM/WB outputs are 0, except inst_wb_o = BUBBLE_INST.
  - Load buffer is 0.
- Decode:
  - is_load = inst[6:0]==7'b0000011; is_store = MemRW_mem_i; mem_op = is_load|is_store; f3 = inst[14:12].
  - Misaligned when: f3[1:0]==01 with addr[0]=1, or f3[1:0]==10 with addr[1:0]!=0. misalign_o is combinational.
  - A misaligned op issues no request, never stalls, and writes MEM/WB with RegWEn_wb_o forced to 0.
- Stores:
  - SB: be = 4'b0001<<addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011<<{addr[1],1'b0}; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111.
  - dmem_we_o = is_store.
  - be and wdata are 0 whenever dmem_req_o=0.
- Loads: select the lane by addr[1:0], then extend.
  - LB / LH: sign-extend.
  - LBU / LHU: zero-extend.
  - LW: pass through.
  - Any other f3 is treated as LW.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE:
    - dmem_req_o = mem_op & ~misalign.
    - If req and ready: access completes. If enable_i is 1, write MEM/WB and stay in IDLE. If enable_i is 0, capture extended data into the load buffer and go to HOLD.
    - If req and not ready: stall_o=1, go to WAIT.
  - WAIT:
    - dmem_req_o=1. Address, we, be and wdata stay stable; inputs are frozen by the hazard unit.
    - stall_o = ~dmem_ready_i.
    - On ready: same completion rule as IDLE.
  - HOLD:
    - dmem_req_o=0, stall_o=0.
    - When enable_i=1, write MEM/WB using the load buffer and return to IDLE.
- Zero-wait memory (ready in the request cycle) gives no stall. Each additional wait cycle adds one stall cycle.
- MEM/WB update, evaluated only when enable_i=1:
  - If reset_i: bubble (all 0, inst = BUBBLE_INST). This has priority over everything else.
  - Else if stall_o: bubble.
  - Else: load the fields. ld_wb_o = extended load data; 0 for non-loads.
  - When enable_i=0, the register holds.
- Flush during WAIT: the bus access still completes (no abort). The FSM then returns to IDLE, with MEM/WB already bubbled.
- Flush in HOLD: MEM/WB is bubbled and the FSM goes to IDLE, discarding the buffer.
- Asserting rst_ni mid-access abandons the transaction immediately; dmem_req_o drops asynchronously.
- Non-memory instructions: no request, no stall; MEM/WB passes fields through.

Test Plan:
- SW x, addr 0x100, rs2=0xDEADBEEF, ready tied 1 -> one cycle of req=1, we=1, be=1111, addr=0x100, stall_o never 1; next cycle RegWEn_wb_o=0.
- LB, addr 0x103, rdata=0x80FF_0000, ready 1 -> ld_wb_o=0xFFFFFF80. LBU with the same inputs -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- LW with ready delayed 3 cycles, rdata=0x12345678 -> stall_o high exactly 3 cycles; MEM/WB bubbles (RegWEn_wb_o=0) during them; then ld_wb_o=0x12345678 with RegWEn_wb_o=1.
- LH at 0x101 -> misalign_o=1, dmem_req_o=0, stall_o=0, RegWEn_wb_o=0 next cycle.
- LW completes with enable_i=0 for 2 cycles (goes to HOLD), rdata changes to garbage afterward -> when enable_i rises, ld_wb_o holds the captured value; no second request is issued.
- SB at 0x102 with rs2=0xAB -> be=0100, wdata=0xABABABAB. Flush (reset_i=1, enable_i=1) in the WAIT state -> bus completes, MEM/WB = bubble with inst_wb_o=0x00000013. rst_ni low mid-WAIT -> req drops immediately and all outputs return to reset values.

Source files
------------

// File: rtl/mem_stage.sv
// RV32I MEM stage: data-memory bus master with lane steering, load extension and the MEM/WB register.
// Latency: one cycle to MEM/WB on zero-wait memory; each bus wait cycle adds one stall_o cycle.
module mem_stage #(
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] alu_mem_i,
  input  logic [31:0] rs2_mem_i,
  input  logic [31:0] pc4_mem_i,
  input  logic        MemRW_mem_i,
  input  logic [1:0]  WBSel_mem_i,
  input  logic        RegWEn_mem_i,
  input  logic [4:0]  rsW_mem_i,
  input  logic [31:0] inst_mem_i,
  input  logic        enable_i,
  input  logic        reset_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [31:0] alu_wb_o,
  output logic [31:0] ld_wb_o,
  output logic [31:0] pc4_wb_o,
  output logic [31:0] inst_wb_o,
  output logic [1:0]  WBSel_wb_o,
  output logic        RegWEn_wb_o,
  output logic [4:0]  rsW_wb_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] ld_buf_q;
  logic        flush_q;

  logic        is_load, is_store, mem_op, misalign;
  logic [2:0]  f3;
  logic [1:0]  a_lo;
  logic        req_raw, stall_raw, done, kill;
  logic [31:0] lane, ld_ext, wdata_raw;
  logic [3:0]  be_raw;

  assign is_load  = (inst_mem_i[6:0] == 7'b0000011);
  assign is_store = MemRW_mem_i;
  assign mem_op   = is_load | is_store;
  assign f3       = inst_mem_i[14:12];
  assign a_lo     = alu_mem_i[1:0];

  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      if (f3[1:0] == 2'b01) misalign = a_lo[0];
      else if (f3[1:0] == 2'b10) misalign = (a_lo != 2'b00);
    end
  end
  assign misalign_o = misalign;

  always_comb begin
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_raw   = mem_op & ~misalign;
        stall_raw = req_raw & ~dmem_ready_i;
      end
      S_WAIT: begin
        req_raw   = 1'b1;
        stall_raw = ~dmem_ready_i;
      end
      default: ;
    endcase
  end

  // Gating with rst_ni lets the request drop the instant reset asserts.
  assign dmem_req_o = req_raw & rst_ni;
  assign stall_o    = stall_raw & rst_ni;
  assign done       = dmem_req_o & dmem_ready_i;
  assign kill       = (state_q == S_WAIT) & flush_q;

  always_comb begin
    case (f3[1:0])
      2'b00: begin
        be_raw    = 4'b0001 << a_lo;
        wdata_raw = {4{rs2_mem_i[7:0]}};
      end
      2'b01: begin
        be_raw    = 4'b0011 << {a_lo[1], 1'b0};
        wdata_raw = {2{rs2_mem_i[15:0]}};
      end
      default: begin
        be_raw    = 4'b1111;
        wdata_raw = rs2_mem_i;
      end
    endcase
  end

  assign dmem_we_o    = is_store;
  assign dmem_addr_o  = {alu_mem_i[31:2], 2'b00};
  assign dmem_be_o    = dmem_req_o ? be_raw : 4'b0000;
  assign dmem_wdata_o = (dmem_req_o & is_store) ? wdata_raw : 32'd0;

  assign lane = dmem_rdata_i >> {a_lo, 3'b000};

  always_comb begin
    case (f3)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'd0, lane[7:0]};
      3'b101:  ld_ext = {16'd0, lane[15:0]};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

  // A flushed access still finishes on the bus, but never parks its data in HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_raw) state_d = !dmem_ready_i ? S_WAIT : (enable_i ? S_IDLE : S_HOLD);
      S_WAIT: if (dmem_ready_i) state_d = (enable_i | flush_q) ? S_IDLE : S_HOLD;
      S_HOLD: if (enable_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      flush_q  <= 1'b0;
      ld_buf_q <= 32'd0;
    end else begin
      state_q <= state_d;
      flush_q <= (state_d == S_WAIT) & (flush_q | (enable_i & reset_i));
      if (done & ~enable_i & ~kill) ld_buf_q <= ld_ext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_wb_o    <= 32'd0;
      ld_wb_o     <= 32'd0;
      pc4_wb_o    <= 32'd0;
      inst_wb_o   <= BUBBLE_INST;
      WBSel_wb_o  <= 2'd0;
      RegWEn_wb_o <= 1'b0;
      rsW_wb_o    <= 5'd0;
    end else if (enable_i) begin
      if (reset_i | stall_o | kill) begin
        alu_wb_o    <= 32'd0;
        ld_wb_o     <= 32'd0;
        pc4_wb_o    <= 32'd0;
        inst_wb_o   <= BUBBLE_INST;
        WBSel_wb_o  <= 2'd0;
        RegWEn_wb_o <= 1'b0;
        rsW_wb_o    <= 5'd0;
      end else begin
        alu_wb_o    <= alu_mem_i;
        pc4_wb_o    <= pc4_mem_i;
        inst_wb_o   <= inst_mem_i;
        WBSel_wb_o  <= WBSel_mem_i;
        RegWEn_wb_o <= RegWEn_mem_i & ~misalign;
        rsW_wb_o    <= rsW_mem_i;
        if (is_load & ~misalign) ld_wb_o <= (state_q == S_HOLD) ? ld_buf_q : ld_ext;
        else ld_wb_o <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB contents queued at issue, popped when a new instruction lands in MEM/WB.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] alu_mem_i, rs2_mem_i, pc4_mem_i, inst_mem_i;
  logic        MemRW_mem_i, RegWEn_mem_i, enable_i, reset_i;
  logic [1:0]  WBSel_mem_i;
  logic [4:0]  rsW_mem_i;
  logic        dmem_req_o, dmem_we_o, dmem_ready_i, stall_o, misalign_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic [31:0] alu_wb_o, ld_wb_o, pc4_wb_o, inst_wb_o;
  logic [1:0]  WBSel_wb_o;
  logic        RegWEn_wb_o;
  logic [4:0]  rsW_wb_o;

  always #5 clk_i = ~clk_i;

  mem_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alu_mem_i(alu_mem_i), .rs2_mem_i(rs2_mem_i), .pc4_mem_i(pc4_mem_i),
    .MemRW_mem_i(MemRW_mem_i), .WBSel_mem_i(WBSel_mem_i), .RegWEn_mem_i(RegWEn_mem_i),
    .rsW_mem_i(rsW_mem_i), .inst_mem_i(inst_mem_i), .enable_i(enable_i), .reset_i(reset_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_rdata_i(dmem_rdata_i),
    .dmem_ready_i(dmem_ready_i), .stall_o(stall_o), .misalign_o(misalign_o),
    .alu_wb_o(alu_wb_o), .ld_wb_o(ld_wb_o), .pc4_wb_o(pc4_wb_o), .inst_wb_o(inst_wb_o),
    .WBSel_wb_o(WBSel_wb_o), .RegWEn_wb_o(RegWEn_wb_o), .rsW_wb_o(rsW_wb_o)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] inst;
    logic        regwen;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ld_inst(input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] st_inst(input logic [2:0] f3, input logic [4:0] rs);
    return {7'd0, rs, 5'd0, f3, 5'd0, 7'b0100011};
  endfunction

  task automatic push_exp(input logic [31:0] alu, input logic [31:0] ld,
                          input logic [31:0] inst, input logic regwen);
    exp_t e;
    e.alu = alu; e.ld = ld; e.inst = inst; e.regwen = regwen;
    sb_q.push_back(e);
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] rs2, input logic memrw,
                        input logic regwen, input logic [4:0] rd, input logic [31:0] inst);
    alu_mem_i = alu; rs2_mem_i = rs2; pc4_mem_i = alu + 32'd4;
    MemRW_mem_i = memrw; RegWEn_mem_i = regwen; rsW_mem_i = rd;
    inst_mem_i = inst; WBSel_mem_i = memrw ? 2'd0 : 2'd1;
  endtask

  task automatic set_nop();
    set_op(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, NOP);
  endtask

  // Single-cycle load with zero-wait memory.
  task automatic load1(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                       input logic [4:0] rd, input logic [31:0] exp_ld);
    @(negedge clk_i);
    set_op(addr, 32'd0, 1'b0, 1'b1, rd, ld_inst(f3, rd));
    dmem_rdata_i = rdata; dmem_ready_i = 1'b1;
    push_exp(addr, exp_ld, ld_inst(f3, rd), 1'b1);
    #1;
    chk("ld1_req", dmem_req_o, 1'b1);
    chk("ld1_stall", stall_o, 1'b0);
    chk("ld1_misalign", misalign_o, 1'b0);
  endtask

  // New non-bubble contents in MEM/WB mean the DUT retired an instruction.
  logic [31:0] prev_inst = NOP;
  always @(posedge clk_i) begin : monitor
    exp_t e;
    #1;
    if (rst_ni && inst_wb_o !== prev_inst && inst_wb_o !== NOP) begin
      chk("sb_has_entry", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_inst", inst_wb_o, e.inst);
        chk("sb_alu", alu_wb_o, e.alu);
        chk("sb_ld", ld_wb_o, e.ld);
        chk("sb_regwen", RegWEn_wb_o, e.regwen);
      end
    end
    prev_inst = inst_wb_o;
  end

  int stalls, reqs;

  initial begin
    rst_ni = 1'b0; enable_i = 1'b1; reset_i = 1'b0;
    dmem_ready_i = 1'b1; dmem_rdata_i = 32'd0;
    set_nop();
    #12;
    chk("rst_inst", inst_wb_o, NOP);
    chk("rst_alu", alu_wb_o, 32'd0);
    chk("rst_ld", ld_wb_o, 32'd0);
    chk("rst_regwen", RegWEn_wb_o, 1'b0);
    chk("rst_req", dmem_req_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    @(negedge clk_i); rst_ni = 1'b1;

    // SW, zero-wait
    @(negedge clk_i);
    set_op(32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, st_inst(3'b010, 5'd2));
    push_exp(32'h100, 32'd0, st_inst(3'b010, 5'd2), 1'b0);
    #1;
    chk("sw_req", dmem_req_o, 1'b1);
    chk("sw_we", dmem_we_o, 1'b1);
    chk("sw_be", dmem_be_o, 4'b1111);
    chk("sw_addr", dmem_addr_o, 32'h100);
    chk("sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
    chk("sw_stall", stall_o, 1'b0);
    @(negedge clk_i); set_nop(); #1;
    chk("sw_req_done", dmem_req_o, 1'b0);
    chk("sw_stall_after", stall_o, 1'b0);

    // Lane select and extension
    load1(3'b000, 32'h103, 32'h80FF_0000, 5'd5, 32'hFFFF_FF80);
    load1(3'b100, 32'h103, 32'h80FF_0000, 5'd6, 32'h0000_0080);
    load1(3'b101, 32'h102, 32'h80FF_0000, 5'd7, 32'h0000_80FF);
    load1(3'b001, 32'h102, 32'h80FF_0000, 5'd8, 32'hFFFF_80FF);

    // LW with three wait cycles
    @(negedge clk_i);
    set_op(32'h200, 32'd0, 1'b0, 1'b1, 5'd9, ld_inst(3'b010, 5'd9));
    dmem_rdata_i = 32'hBAD0_BAD0; dmem_ready_i = 1'b0;
    push_exp(32'h200, 32'h1234_5678, ld_inst(3'b010, 5'd9), 1'b1);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall_o) stalls++;
      chk("lw_wait_addr", dmem_addr_o, 32'h200);
      @(posedge clk_i); #2;
      chk("lw_bubble_regwen", RegWEn_wb_o, 1'b0);
      chk("lw_bubble_inst", inst_wb_o, NOP);
      @(negedge clk_i);
    end
    dmem_ready_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    #1;
    if (stall_o) stalls++;
    chk("lw_done_req", dmem_req_o, 1'b1);
    chk("lw_stall_cycles", stalls, 3);

    // Misaligned LH
    @(negedge clk_i);
    set_op(32'h101, 32'd0, 1'b0, 1'b1, 5'd10, ld_inst(3'b001, 5'd10));
    dmem_rdata_i = 32'd0;
    push_exp(32'h101, 32'd0, ld_inst(3'b001, 5'd10), 1'b0);
    #1;
    chk("mis_flag", misalign_o, 1'b1);
    chk("mis_req", dmem_req_o, 1'b0);
    chk("mis_stall", stall_o, 1'b0);

    // LW completes while MEM/WB is frozen, then data changes on the bus
    @(negedge clk_i);
    set_op(32'h300, 32'd0, 1'b0, 1'b1, 5'd11, ld_inst(3'b010, 5'd11));
    dmem_rdata_i = 32'hCAFE_F00D; dmem_ready_i = 1'b1; enable_i = 1'b0;
    push_exp(32'h300, 32'hCAFE_F00D, ld_inst(3'b010, 5'd11), 1'b1);
    reqs = 0;
    #1; if (dmem_req_o) reqs++;
    chk("hold_stall0", stall_o, 1'b0);
    @(negedge clk_i); dmem_rdata_i = 32'h0BAD_BEEF;
    #1; if (dmem_req_o) reqs++;
    chk("hold_stall1", stall_o, 1'b0);
    chk("hold_keep_wb", inst_wb_o, ld_inst(3'b001, 5'd10));
    @(negedge clk_i); enable_i = 1'b1;
    #1; if (dmem_req_o) reqs++;
    @(negedge clk_i); set_nop();
    chk("hold_one_req", reqs, 1);

    // SB lane steering
    @(negedge clk_i);
    set_op(32'h102, 32'h0000_00AB, 1'b1, 1'b0, 5'd0, st_inst(3'b000, 5'd3));
    push_exp(32'h102, 32'd0, st_inst(3'b000, 5'd3), 1'b0);
    #1;
    chk("sb_be", dmem_be_o, 4'b0100);
    chk("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
    chk("sb_we", dmem_we_o, 1'b1);

    // Flush while waiting: access finishes, result discarded
    @(negedge clk_i);
    set_op(32'h10C, 32'd0, 1'b0, 1'b1, 5'd12, ld_inst(3'b010, 5'd12));
    dmem_ready_i = 1'b0; dmem_rdata_i = 32'd0;
    #1; chk("fl_stall0", stall_o, 1'b1);
    @(negedge clk_i); reset_i = 1'b1;
    #1;
    chk("fl_req_wait", dmem_req_o, 1'b1);
    chk("fl_stall_wait", stall_o, 1'b1);
    @(posedge clk_i); #2;
    chk("fl_bubble_inst", inst_wb_o, NOP);
    @(negedge clk_i); reset_i = 1'b0; dmem_ready_i = 1'b1; dmem_rdata_i = 32'h55AA_55AA;
    #1;
    chk("fl_req_done", dmem_req_o, 1'b1);
    chk("fl_stall_done", stall_o, 1'b0);
    @(posedge clk_i); #2;
    chk("fl_done_inst", inst_wb_o, NOP);
    chk("fl_done_regwen", RegWEn_wb_o, 1'b0);
    chk("fl_done_ld", ld_wb_o, 32'd0);
    @(negedge clk_i);
    set_op(32'h110, 32'd0, 1'b0, 1'b1, 5'd13, ld_inst(3'b010, 5'd13));
    dmem_rdata_i = 32'h1122_3344;
    push_exp(32'h110, 32'h1122_3344, ld_inst(3'b010, 5'd13), 1'b1);
    #1;
    chk("fl_idle_req", dmem_req_o, 1'b1);
    chk("fl_idle_stall", stall_o, 1'b0);

    // Non-memory op, then async reset in the middle of a wait
    @(negedge clk_i);
    set_op(32'h55, 32'd0, 1'b0, 1'b1, 5'd3, 32'h00A0_0193);
    push_exp(32'h55, 32'd0, 32'h00A0_0193, 1'b1);
    #1;
    chk("alu_req", dmem_req_o, 1'b0);
    chk("alu_stall", stall_o, 1'b0);
    chk("alu_misalign", misalign_o, 1'b0);
    @(negedge clk_i);
    set_op(32'h400, 32'd0, 1'b0, 1'b1, 5'd14, ld_inst(3'b010, 5'd14));
    dmem_ready_i = 1'b0; enable_i = 1'b0;
    #1; chk("rw_stall", stall_o, 1'b1);
    @(negedge clk_i); #1;
    chk("rw_req_wait", dmem_req_o, 1'b1);
    chk("rw_alu_held", alu_wb_o, 32'h55);
    #2; rst_ni = 1'b0;
    #1;
    chk("rw_req_drop", dmem_req_o, 1'b0);
    chk("rw_stall_drop", stall_o, 1'b0);
    chk("rw_inst", inst_wb_o, NOP);
    chk("rw_alu", alu_wb_o, 32'd0);
    chk("rw_pc4", pc4_wb_o, 32'd0);
    chk("rw_regwen", RegWEn_wb_o, 1'b0);
    chk("rw_rsw", rsW_wb_o, 5'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; set_nop(); enable_i = 1'b1; dmem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
